// File: rtl/order_fifo_slave.sv
// AXI4-Lite slave for the host order channel: stages four operands and commits
// {opcode, operands} into an order FIFO drained by the core controller.
module order_fifo_slave #(
    parameter int AXIL_DATA_WIDTH = 32,
    parameter int AXIL_ADDR_WIDTH = 8,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                       s00_axi_aclk,
    input  logic                       s00_axi_aresetn,
    input  logic [AXIL_ADDR_WIDTH-1:0] s00_axi_awaddr,
    input  logic                       s00_axi_awvalid,
    output logic                       s00_axi_awready,
    input  logic [AXIL_DATA_WIDTH-1:0] s00_axi_wdata,
    input  logic [3:0]                 s00_axi_wstrb,
    input  logic                       s00_axi_wvalid,
    output logic                       s00_axi_wready,
    output logic [1:0]                 s00_axi_bresp,
    output logic                       s00_axi_bvalid,
    input  logic                       s00_axi_bready,
    input  logic [AXIL_ADDR_WIDTH-1:0] s00_axi_araddr,
    input  logic                       s00_axi_arvalid,
    output logic                       s00_axi_arready,
    output logic [AXIL_DATA_WIDTH-1:0] s00_axi_rdata,
    output logic [1:0]                 s00_axi_rresp,
    output logic                       s00_axi_rvalid,
    input  logic                       s00_axi_rready,
    output logic [159:0]               order_data,
    output logic                       order_valid,
    input  logic                       order_ready
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [5:0] ADDR_DOORBELL = 6'h12;
    localparam logic [5:0] ADDR_SPACE    = 6'h13;
    localparam logic [5:0] ADDR_COUNT    = 6'h14;
    localparam logic [5:0] ADDR_STATUS   = 6'h15;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic                       wr_ready;
    logic [AXIL_DATA_WIDTH-1:0] op [4];
    logic [159:0]               mem [FIFO_DEPTH];
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [CNT_W-1:0]           count;
    logic                       overflow;
    logic [AXIL_DATA_WIDTH-1:0] rd_value;

    logic [5:0] wr_idx;
    logic [5:0] rd_idx;
    logic       wr_accept;
    logic       rd_accept;
    logic       full;
    logic       doorbell;
    logic       push;
    logic       pop;
    logic       unused_addr_bits;

    assign wr_idx    = s00_axi_awaddr[7:2];
    assign rd_idx    = s00_axi_araddr[7:2];
    assign wr_accept = wr_ready & s00_axi_awvalid & s00_axi_wvalid;
    assign rd_accept = s00_axi_arready & s00_axi_arvalid;
    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign doorbell  = wr_accept && (wr_idx == ADDR_DOORBELL);
    assign push      = doorbell && !full;
    assign pop       = order_valid && order_ready;

    assign unused_addr_bits = ^{s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    assign s00_axi_awready = wr_ready;
    assign s00_axi_wready  = wr_ready;
    assign s00_axi_rresp   = RESP_OKAY;

    assign order_valid = (count != '0);
    assign order_data  = order_valid ? mem[rd_ptr] : '0;

    // AW and W are taken together, and only while no response is outstanding.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            wr_ready       <= 1'b0;
            s00_axi_bvalid <= 1'b0;
            s00_axi_bresp  <= RESP_OKAY;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            wr_ready <= s00_axi_awvalid & s00_axi_wvalid & !s00_axi_bvalid & !wr_ready;
            if (wr_accept) begin
                s00_axi_bvalid <= 1'b1;
                s00_axi_bresp  <= (doorbell && full) ? RESP_SLVERR : RESP_OKAY;
            end else if (s00_axi_bvalid && s00_axi_bready) begin
                s00_axi_bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            for (int i = 0; i < 4; i++) op[i] <= '0;
        end else if (wr_accept) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_idx == 6'(i)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (s00_axi_wstrb[b]) op[i][8*b +: 8] <= s00_axi_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    // NOTE: FIFO storage is deliberately not reset; order_data is gated by
    // order_valid so stale or unknown entries never reach the controller.
    always_ff @(posedge s00_axi_aclk) begin
        if (push) mem[wr_ptr] <= {s00_axi_wdata, op[3], op[2], op[1], op[0]};
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            // Full is judged on the pre-edge count, so a same-cycle pop does not rescue the push.
            if (doorbell && full) begin
                overflow <= 1'b1;
            end else if (wr_accept && wr_idx == ADDR_STATUS && s00_axi_wstrb[0] && s00_axi_wdata[0]) begin
                overflow <= 1'b0;
            end
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns rd_value and no latch is inferred.
        rd_value = '0;
        case (rd_idx)
            6'h00:       rd_value = op[0];
            6'h01:       rd_value = op[1];
            6'h02:       rd_value = op[2];
            6'h03:       rd_value = op[3];
            ADDR_SPACE:  rd_value = AXIL_DATA_WIDTH'(!full);
            ADDR_COUNT:  rd_value = AXIL_DATA_WIDTH'(count);
            ADDR_STATUS: rd_value = AXIL_DATA_WIDTH'(overflow);
            default:     rd_value = '0;
        endcase
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            s00_axi_arready <= 1'b0;
            s00_axi_rvalid  <= 1'b0;
            s00_axi_rdata   <= '0;
        end else begin
            s00_axi_arready <= s00_axi_arvalid & !s00_axi_rvalid & !s00_axi_arready;
            if (rd_accept) begin
                s00_axi_rvalid <= 1'b1;
                s00_axi_rdata  <= rd_value;
            end else if (s00_axi_rvalid && s00_axi_rready) begin
                s00_axi_rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_order_fifo_slave.sv
// Directed bench for order_fifo_slave: register access, doorbell commit,
// overflow, full push/pop, byte strobes, back-pressure and mid-flight reset.
module tb_order_fifo_slave;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   awaddr = '0;
    logic         awvalid = 1'b0;
    logic         awready;
    logic [31:0]  wdata = '0;
    logic [3:0]   wstrb = '0;
    logic         wvalid = 1'b0;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready = 1'b1;
    logic [7:0]   araddr = '0;
    logic         arvalid = 1'b0;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready = 1'b1;
    logic [159:0] order_data;
    logic         order_valid;
    logic         order_ready = 1'b0;

    int tests_run    = 0;
    int tests_failed = 0;

    logic ov_pre;
    logic ov_post;
    logic bv_post;

    always #5 clk = ~clk;

    order_fifo_slave #(.AXIL_DATA_WIDTH(32), .AXIL_ADDR_WIDTH(8), .FIFO_DEPTH(8)) dut (
        .s00_axi_aclk(clk),
        .s00_axi_aresetn(rst_n),
        .s00_axi_awaddr(awaddr),
        .s00_axi_awvalid(awvalid),
        .s00_axi_awready(awready),
        .s00_axi_wdata(wdata),
        .s00_axi_wstrb(wstrb),
        .s00_axi_wvalid(wvalid),
        .s00_axi_wready(wready),
        .s00_axi_bresp(bresp),
        .s00_axi_bvalid(bvalid),
        .s00_axi_bready(bready),
        .s00_axi_araddr(araddr),
        .s00_axi_arvalid(arvalid),
        .s00_axi_arready(arready),
        .s00_axi_rdata(rdata),
        .s00_axi_rresp(rresp),
        .s00_axi_rvalid(rvalid),
        .s00_axi_rready(rready),
        .order_data(order_data),
        .order_valid(order_valid),
        .order_ready(order_ready)
    );

    // Full write transaction with bready high; optionally pops the FIFO on the accept edge.
    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic pop_at_accept,
                             output logic [1:0] resp);
        bit seen = 0;
        resp = 2'bxx;
        @(negedge clk);
        awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (awready === 1'b1 && wready === 1'b1) begin seen = 1; break; end
        end
        if (!seen) begin
            tests_run++; tests_failed++;
            $display("FAIL write_accept_timeout addr=%h", addr);
            awvalid = 1'b0; wvalid = 1'b0;
            return;
        end
        ov_pre = order_valid;
        if (pop_at_accept) order_ready = 1'b1;
        @(posedge clk);
        #1 awvalid = 1'b0; wvalid = 1'b0; order_ready = 1'b0;
        @(negedge clk);
        bv_post = bvalid; ov_post = order_valid;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (bvalid === 1'b1) begin seen = 1; break; end
            @(negedge clk);
        end
        if (!seen) begin
            tests_run++; tests_failed++;
            $display("FAIL write_resp_timeout addr=%h", addr);
            return;
        end
        resp = bresp;
        @(posedge clk);
        #1;
    endtask

    task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
        bit seen = 0;
        data = 'x; resp = 2'bxx;
        @(negedge clk);
        araddr = addr; arvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (arready === 1'b1) begin seen = 1; break; end
        end
        if (!seen) begin
            tests_run++; tests_failed++;
            $display("FAIL read_accept_timeout addr=%h", addr);
            arvalid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 arvalid = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rvalid === 1'b1) begin seen = 1; break; end
        end
        if (!seen) begin
            tests_run++; tests_failed++;
            $display("FAIL read_resp_timeout addr=%h", addr);
            return;
        end
        data = rdata; resp = rresp;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_read(input string name, input logic [7:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        logic [1:0]  r;
        axi_read(addr, d, r);
        tests_run++;
        if (d !== exp || r !== 2'b00) begin
            tests_failed++;
            $display("FAIL %s: got data=%h resp=%b, want data=%h resp=00", name, d, r, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata, order_valid} !== '0
            || order_data !== 160'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: aw=%b w=%b ar=%b bv=%b rv=%b bresp=%b rresp=%b rdata=%h ov=%b od=%h, want all 0",
                     awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata, order_valid, order_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
        expect_read("reset_space", 8'h4C, 32'd1);
        expect_read("reset_count", 8'h50, 32'd0);
        expect_read("reset_op0",   8'h00, 32'd0);
        expect_read("reset_overflow", 8'h54, 32'd0);
    endtask

    task automatic test_single_order();
        logic [1:0] r;
        axi_write(8'h00, 32'h11111111, 4'hF, 1'b0, r);
        axi_write(8'h04, 32'h22222222, 4'hF, 1'b0, r);
        axi_write(8'h08, 32'h33333333, 4'hF, 1'b0, r);
        axi_write(8'h0C, 32'h44444444, 4'hF, 1'b0, r);
        expect_read("op3_readback", 8'h0C, 32'h44444444);
        axi_write(8'h48, 32'h000000A5, 4'hF, 1'b0, r);
        tests_run++;
        if (r !== 2'b00 || ov_pre !== 1'b0 || ov_post !== 1'b1 || bv_post !== 1'b1) begin
            tests_failed++;
            $display("FAIL doorbell_timing: resp=%b ov_pre=%b ov_post=%b bv_post=%b, want 00 0 1 1", r, ov_pre, ov_post, bv_post);
        end
        tests_run++;
        if (order_data !== {32'hA5, 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}) begin
            tests_failed++;
            $display("FAIL doorbell_data: got %h", order_data);
        end
        expect_read("single_count", 8'h50, 32'd1);
        expect_read("op0_kept", 8'h00, 32'h11111111);
        expect_read("doorbell_reads_zero", 8'h48, 32'd0);
        @(negedge clk) order_ready = 1'b1;
        @(posedge clk) #1 order_ready = 1'b0;
        @(negedge clk);
        tests_run++;
        if (order_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL pop_to_empty: order_valid=%b want 0", order_valid);
        end
    endtask

    task automatic test_overflow();
        logic [1:0] r;
        for (int i = 0; i < 9; i++) begin
            axi_write(8'h48, 32'(i), 4'hF, 1'b0, r);
            tests_run++;
            if (r !== ((i < 8) ? 2'b00 : 2'b10)) begin
                tests_failed++;
                $display("FAIL overflow_resp[%0d]: got %b want %b", i, r, (i < 8) ? 2'b00 : 2'b10);
            end
        end
        expect_read("full_space", 8'h4C, 32'd0);
        expect_read("full_count", 8'h50, 32'd8);
        expect_read("overflow_set", 8'h54, 32'd1);
        axi_write(8'h54, 32'd1, 4'hF, 1'b0, r);
        expect_read("overflow_cleared", 8'h54, 32'd0);
    endtask

    task automatic test_full_push_pop();
        logic [1:0] r;
        axi_write(8'h48, 32'h99, 4'hF, 1'b1, r);
        tests_run++;
        if (r !== 2'b10) begin
            tests_failed++;
            $display("FAIL full_push_pop_resp: got %b want 10", r);
        end
        expect_read("full_push_pop_count", 8'h50, 32'd7);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            tests_run++;
            if (order_valid !== 1'b1 || order_data !== {32'(k), 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}) begin
                tests_failed++;
                $display("FAIL drain_order[%0d]: valid=%b data=%h want opcode %0d", k, order_valid, order_data, k);
            end
            order_ready = 1'b1;
            @(posedge clk) #1 order_ready = 1'b0;
        end
        @(negedge clk);
        tests_run++;
        if (order_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL drain_empty: order_valid=%b want 0", order_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] r;
        bit seen = 0;
        int bad = 0;
        axi_write(8'h00, 32'h0, 4'hF, 1'b0, r);
        axi_write(8'h00, 32'hDEADBEEF, 4'b0010, 1'b0, r);
        expect_read("wstrb_op0", 8'h00, 32'h0000BE00);
        @(negedge clk);
        bready = 1'b0;
        awaddr = 8'h04; wdata = 32'h12345678; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (awready === 1'b1) begin seen = 1; break; end
        end
        @(posedge clk);
        #1 awaddr = 8'h08; wdata = 32'hCAFEF00D;
        repeat (5) begin
            @(negedge clk);
            if (bvalid !== 1'b1 || awready !== 1'b0 || wready !== 1'b0) bad++;
        end
        tests_run++;
        if (!seen || bad != 0) begin
            tests_failed++;
            $display("FAIL backpressure_hold: accepted=%0d bad_cycles=%0d want 1 0", seen, bad);
        end
        bready = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (awready === 1'b1) begin seen = 1; break; end
        end
        @(posedge clk);
        #1 awvalid = 1'b0; wvalid = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (!seen || bvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL second_write: accepted=%0d bvalid=%b want 1 0", seen, bvalid);
        end
        expect_read("backpressure_op1", 8'h04, 32'h12345678);
        expect_read("backpressure_op2", 8'h08, 32'hCAFEF00D);
    endtask

    task automatic test_reset_mid();
        logic [1:0] r;
        for (int i = 0; i < 3; i++) axi_write(8'h48, 32'h70 + 32'(i), 4'hF, 1'b0, r);
        @(negedge clk);
        bready = 1'b0;
        awaddr = 8'h00; wdata = 32'h5A5A5A5A; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (awready === 1'b1) break;
        end
        @(posedge clk);
        #1 awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bvalid !== 1'b1 || order_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL pre_reset_state: bvalid=%b order_valid=%b want 1 1", bvalid, order_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (bvalid !== 1'b0 || order_valid !== 1'b0 || order_data !== 160'd0) begin
            tests_failed++;
            $display("FAIL async_reset: bvalid=%b order_valid=%b order_data=%h want 0 0 0", bvalid, order_valid, order_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bready = 1'b1;
        repeat (4) @(negedge clk);
        tests_run++;
        if (bvalid !== 1'b0 || rvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset_quiet: bvalid=%b rvalid=%b want 0 0", bvalid, rvalid);
        end
        expect_read("post_reset_count", 8'h50, 32'd0);
        expect_read("post_reset_op0", 8'h00, 32'd0);
    endtask

    initial begin
        test_reset();
        test_single_order();
        test_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/order_fifo_slave.md
# order_fifo_slave

AXI4-Lite slave that terminates the host order channel of the accelerator core and buffers committed orders for the controller. Four operand registers are staged by ordinary writes. A doorbell write to 0x48 commits {opcode, operands} as one 160-bit order into a FIFO. The host polls 0x4C for space before each doorbell; the core controller drains the FIFO through a valid/ready port.

## Interface
- AXIL_DATA_WIDTH, 32: AXI-Lite data width; only 32 is supported.
- AXIL_ADDR_WIDTH, 8: AXI-Lite address width; decode uses addr[7:2].
- FIFO_DEPTH, 8: order FIFO entries; power of two, ≥2.
- s00_axi_aclk  in  1  single clock for all logic.
- s00_axi_aresetn  in  1  asynchronous, active-low reset.
- s00_axi_awaddr / awvalid / awready  in/in/out  AXIL_ADDR_WIDTH/1/1  write address channel (awprot ignored).
- s00_axi_wdata / wstrb / wvalid / wready  in/in/in/out  32/4/1/1  write data channel.
- s00_axi_bresp / bvalid / bready  out/out/in  2/1/1  write response.
- s00_axi_araddr / arvalid / arready  in/in/out  AXIL_ADDR_WIDTH/1/1  read address (arprot ignored).
- s00_axi_rdata / rresp / rvalid / rready  out/out/out/in  32/2/1/1  read data.
- order_data  out  160  {opcode[159:128], op3, op2, op1, op0}.
- order_valid  out  1  FIFO head valid.
- order_ready  in  1  controller pops head when order_valid & order_ready.

## Operation
- Register map:
  - 0x00/0x04/0x08/0x0C: op0..op3, R/W, WSTRB byte enables honoured.
  - 0x48: doorbell, W only; reads return 0.
  - 0x4C: RO, 1 when FIFO not full, else 0.
  - 0x50: RO, FIFO count, 0..FIFO_DEPTH.
  - 0x54: bit0 overflow sticky, write 1 to clear.
  - Other addresses: reads return 0 with OKAY; writes are ignored with OKAY.
- Write channel:
  - awready and wready pulse high together for one cycle when awvalid & wvalid & !bvalid. AW is never accepted without W.
  - bvalid rises the cycle after acceptance and holds until bready.
- Doorbell write:
  - FIFO not full: pushes {wdata, op3, op2, op1, op0} using the operand values before this write; bresp OKAY (2'b00).
  - FIFO full: order dropped, overflow set, bresp SLVERR (2'b10). WSTRB is ignored.
  - Operand registers keep their values after commit.
- Read channel: arready pulses one cycle when arvalid & !rvalid. rdata/rresp are registered from state at the accept cycle; rvalid holds until rready.
- FIFO: circular buffer, pointers wrap modulo FIFO_DEPTH. Count is tracked separately so full (count==FIFO_DEPTH) and empty are distinct. order_data is the head entry.

## Timing
- Reset (async assert, sync release): awready, wready, arready, bvalid, rvalid = 0. bresp, rresp, rdata = 0. order_valid = 0, order_data = 0. Operands, pointers, count and overflow = 0.
- Write accepted at edge T: register/FIFO updated at T; bvalid high from T+1. The next write can be accepted at the edge where bvalid&bready is seen + 1 cycle.
- Read accepted at edge T: rvalid high from T+1 with data reflecting state before edge T.
- Doorbell push at T: order_valid high from T+1 if the FIFO was empty (fall-through latency 1).
- Pop at T: head advances at T; order_valid drops at T+1 if the FIFO became empty.
- Simultaneous push and pop:
  - Not full: count unchanged, both take effect.
  - Full: push rejected even though a pop occurs the same cycle (full is judged on the pre-edge count).
- Reset mid-transaction: all outstanding responses and FIFO contents are discarded; no bvalid/rvalid after reset release until a new request.

## Test plan
- Reset then read 0x4C, 0x50, 0x00 -> rdata 1, 0, 0; rresp OKAY; every reset value checked.
- Write op0..op3 = 0x11111111..0x44444444, doorbell 0x48 = 0xA5 -> order_valid at T+1, order_data = {0xA5, 0x44444444, 0x33333333, 0x22222222, 0x11111111}, 0x50 reads 1.
- order_ready low, 9 doorbells with FIFO_DEPTH=8 -> first 8 OKAY, 9th SLVERR; 0x4C = 0, 0x54 = 1; write 1 to 0x54 -> reads 0.
- Full FIFO, order_ready=1 for one cycle concurrent with a doorbell -> doorbell SLVERR, count 7, entries drain in push order.
- WSTRB=4'b0010 write of 0xDEADBEEF to op0 = 0 -> op0 reads 0x0000BE00; bready held low 5 cycles -> bvalid stays high, no new AW/W accepted.
- Reset asserted while bvalid is high and FIFO holds 3 entries -> bvalid and order_valid drop immediately; count reads 0 after release.
